// File: rtl/mem_responder.sv
// Word-organised RAM target for the core's rd_en/wr_en/byte_en/ack bus.
// Each accepted request waits BUSY_CYCLES and then returns a one-cycle ack.
module mem_responder #(
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned DEPTH_LOG2  = 10,
  parameter int unsigned BUSY_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [DATA_SIZE/8-1:0] byte_en,
  input  logic [ADDR_SIZE-1:0]   addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   ack
);

  localparam int unsigned BYTE_NUM = DATA_SIZE / 8;
  localparam int unsigned OFF_W    = $clog2(BYTE_NUM);
  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W    = (BUSY_CYCLES == 0) ? 1 : $clog2(BUSY_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [BYTE_NUM-1:0]     be_q;
  logic [DATA_SIZE-1:0]    wdata_q;
  logic [DATA_SIZE-1:0]    rd_data_q;
  logic                    ack_q;

  logic                    capture;
  logic                    do_access;
  logic                    op_we;
  logic [DEPTH_LOG2-1:0]   op_idx;
  logic [BYTE_NUM-1:0]     op_be;
  logic [DATA_SIZE-1:0]    op_wdata;
  logic [DATA_SIZE-1:0]    rd_masked;
  logic [DEPTH_LOG2-1:0]   req_idx;
  logic                    unused_addr;

  logic [DATA_SIZE-1:0]    mem [DEPTH];

  // Offset bits and bits above the RAM size are deliberately ignored.
  assign req_idx     = addr[OFF_W +: DEPTH_LOG2];
  assign unused_addr = ^addr;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture   = 1'b0;
    do_access = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rd_en || wr_en) begin
          capture = 1'b1;
          cnt_d   = CNT_W'(BUSY_CYCLES);
          if (BUSY_CYCLES == 0) begin
            state_d   = StAck;
            do_access = 1'b1;
          end else begin
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        if (!(rd_en || wr_en)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d   = StAck;
          do_access = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With zero wait states the access happens on the accepting edge, so use live inputs.
  always_comb begin
    op_we    = capture ? wr_en   : we_q;
    op_idx   = capture ? req_idx : idx_q;
    op_be    = capture ? byte_en : be_q;
    op_wdata = capture ? wr_data : wdata_q;
  end

  always_comb begin
    rd_masked = '0;
    for (int i = 0; i < BYTE_NUM; i++) begin
      if (op_be[i]) rd_masked[8*i +: 8] = mem[op_idx][8*i +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      ack_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= do_access;
      if (capture) begin
        we_q    <= wr_en;
        idx_q   <= req_idx;
        be_q    <= byte_en;
        wdata_q <= wr_data;
      end
      if (do_access && !op_we) rd_data_q <= rd_masked;
    end
  end

  // RAM is never cleared; writes are gated by reset so an aborted access leaves it intact.
  always_ff @(posedge clock) begin
    if (do_access && op_we && !reset) begin
      for (int i = 0; i < BYTE_NUM; i++) begin
        if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
      end
    end
  end

  assign rd_data = rd_data_q;
  assign ack     = ack_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomised and directed checks of mem_responder against a word-array model,
// using a 2-wait-state / 1024-word instance and a 0-wait-state / 16-word instance.
module tb_mem_responder;

  logic        clock;
  logic        reset;
  logic        rd_en_a, wr_en_a, ack_a;
  logic [3:0]  be_a;
  logic [31:0] addr_a, wdata_a, rd_data_a;
  logic        rd_en_b, wr_en_b, ack_b;
  logic [3:0]  be_b;
  logic [31:0] addr_b, wdata_b, rd_data_b;

  int tests = 0;
  int fails = 0;

  // Reference model: [0] is the 1024-word instance, [1] the 16-word instance.
  logic [31:0] ref_mem [2][1024];
  logic [31:0] ref_rd  [2];

  mem_responder #(
    .DATA_SIZE(32), .ADDR_SIZE(32), .DEPTH_LOG2(10), .BUSY_CYCLES(2)
  ) u_dut (
    .clock(clock), .reset(reset), .rd_en(rd_en_a), .wr_en(wr_en_a), .byte_en(be_a),
    .addr(addr_a), .wr_data(wdata_a), .rd_data(rd_data_a), .ack(ack_a)
  );

  mem_responder #(
    .DATA_SIZE(32), .ADDR_SIZE(32), .DEPTH_LOG2(4), .BUSY_CYCLES(0)
  ) u_dut0 (
    .clock(clock), .reset(reset), .rd_en(rd_en_b), .wr_en(wr_en_b), .byte_en(be_b),
    .addr(addr_b), .wr_data(wdata_b), .rd_data(rd_data_b), .ack(ack_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_bus(input bit sel, input bit rd, input bit wr, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] d);
    if (sel) begin
      rd_en_b = rd; wr_en_b = wr; be_b = be; addr_b = a; wdata_b = d;
    end else begin
      rd_en_a = rd; wr_en_a = wr; be_a = be; addr_a = a; wdata_a = d;
    end
  endtask

  function automatic logic ack_of(input bit sel);
    return sel ? ack_b : ack_a;
  endfunction

  function automatic logic [31:0] rd_of(input bit sel);
    return sel ? rd_data_b : rd_data_a;
  endfunction

  function automatic int widx(input bit sel, input logic [31:0] a);
    return sel ? int'((a >> 2) % 16) : int'((a >> 2) % 1024);
  endfunction

  // Wait states + 1: cycles from raising the request to seeing ack.
  function automatic int lat_of(input bit sel);
    return sel ? 1 : 3;
  endfunction

  task automatic xact(input bit sel, input bit rd, input bit wr, input logic [3:0] be,
                      input logic [31:0] a, input logic [31:0] d, input bit b2b,
                      input string tag);
    int n;
    bit got;
    int idx;
    idx = widx(sel, a);
    if (!b2b) begin
      @(posedge clock); #1;
    end
    set_bus(sel, rd, wr, be, a, d);
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clock); #1;
      n++;
      got = ack_of(sel);
    end
    set_bus(sel, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check({tag, "_lat"}, 32'(n), 32'(lat_of(sel)));
    if (wr) begin
      for (int i = 0; i < 4; i++) if (be[i]) ref_mem[sel][idx][8*i +: 8] = d[8*i +: 8];
    end else begin
      ref_rd[sel] = 32'h0;
      for (int i = 0; i < 4; i++) if (be[i]) ref_rd[sel][8*i +: 8] = ref_mem[sel][idx][8*i +: 8];
    end
    check({tag, "_rd"}, rd_of(sel), ref_rd[sel]);
    @(posedge clock); #1;
    check({tag, "_ackpulse"}, 32'(ack_of(sel)), 32'h0);
  endtask

  initial begin
    bit saw;
    int r;
    logic [31:0] a, d;
    reset = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_bus(1'b1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    ref_rd[0] = 32'h0;
    ref_rd[1] = 32'h0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("rst_ack", 32'(ack_a), 32'h0);
    check("rst_rd", rd_data_a, 32'h0);
    check("rst_ack0", 32'(ack_b), 32'h0);
    check("rst_rd0", rd_data_b, 32'h0);

    xact(1'b0, 1'b0, 1'b1, 4'hF, 32'h10, 32'h11223344, 1'b0, "pre_w4");
    xact(1'b0, 1'b0, 1'b1, 4'hF, 32'h14, 32'h55667788, 1'b0, "pre_w5");
    xact(1'b0, 1'b0, 1'b1, 4'hF, 32'h0,  32'h01020304, 1'b0, "pre_w0");
    xact(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, "rd_w4");
    check("rd_w4_val", rd_data_a, 32'h11223344);

    xact(1'b0, 1'b0, 1'b1, 4'h3, 32'h10, 32'hAABBCCDD, 1'b0, "wr_lo");
    xact(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, "rd_merge");
    check("rd_merge_val", rd_data_a, 32'h1122CCDD);
    xact(1'b0, 1'b1, 1'b0, 4'h1, 32'h10, 32'h0, 1'b0, "rd_lane0");
    check("rd_lane0_val", rd_data_a, 32'h000000DD);

    // Back-to-back: second request raised in the idle cycle after the first ack.
    xact(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, "b2b_1");
    xact(1'b0, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 1'b1, "b2b_2");
    check("b2b_val", rd_data_a, 32'h55667788);

    // Abort after one wait state.
    @(posedge clock); #1;
    set_bus(1'b0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hFFFFFFFF);
    @(posedge clock);
    @(posedge clock); #1;
    set_bus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clock); #1;
      if (ack_a) saw = 1'b1;
    end
    check("abort_no_ack", 32'(saw), 32'h0);
    check("abort_rd_hold", rd_data_a, 32'h55667788);
    xact(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, "abort_mem");
    check("abort_mem_val", rd_data_a, 32'h1122CCDD);

    // Reset in the middle of a write's wait states.
    @(posedge clock); #1;
    set_bus(1'b0, 1'b0, 1'b1, 4'hF, 32'h14, 32'hDEADBEEF);
    @(posedge clock); #1;
    #2 reset = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    #3 reset = 1'b0;
    ref_rd[0] = 32'h0;
    ref_rd[1] = 32'h0;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      if (ack_a) saw = 1'b1;
    end
    check("rstbusy_no_ack", 32'(saw), 32'h0);
    check("rstbusy_rd0", rd_data_a, 32'h0);
    xact(1'b0, 1'b1, 1'b0, 4'hF, 32'h14, 32'h0, 1'b0, "rstbusy_rd");
    check("rstbusy_val", rd_data_a, 32'h55667788);

    // Wrap modulo RAM size, and rd_en+wr_en counts as a write.
    xact(1'b0, 1'b1, 1'b1, 4'hF, 32'h1000, 32'h5A5A5A5A, 1'b0, "wrap_w");
    xact(1'b0, 1'b1, 1'b0, 4'hF, 32'h0, 32'h0, 1'b0, "wrap_rd");
    check("wrap_val", rd_data_a, 32'h5A5A5A5A);

    // Empty byte enables.
    xact(1'b0, 1'b0, 1'b1, 4'h0, 32'h10, 32'h0BADF00D, 1'b0, "be0_w");
    xact(1'b0, 1'b1, 1'b0, 4'h0, 32'h10, 32'h0, 1'b0, "be0_rd");
    check("be0_rd_val", rd_data_a, 32'h0);
    xact(1'b0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, "be0_keep");
    check("be0_keep_val", rd_data_a, 32'h1122CCDD);

    // Random traffic over words 0..15 with random wrap bits and offsets.
    for (int w = 0; w < 16; w++) begin
      xact(1'b0, 1'b0, 1'b1, 4'hF, 32'(w * 4), $urandom, 1'b0, "init_a");
      xact(1'b1, 1'b0, 1'b1, 4'hF, 32'(w * 4), $urandom, 1'b0, "init_b");
    end
    for (int k = 0; k < 30; k++) begin
      r = int'($urandom_range(2, 0));
      a = ($urandom & 32'hFFFFF000) | (32'($urandom_range(15, 0)) << 2) | ($urandom & 32'h3);
      d = $urandom;
      xact(1'b0, r == 0, r != 0, 4'($urandom), a, d, 1'b0, "rnd_a");
    end
    xact(1'b1, 1'b0, 1'b1, 4'hF, 32'h48, 32'hC0FFEE11, 1'b0, "b_wrap_w");
    xact(1'b1, 1'b1, 1'b0, 4'hF, 32'h8, 32'h0, 1'b0, "b_wrap_rd");
    check("b_wrap_val", rd_data_b, 32'hC0FFEE11);
    for (int k = 0; k < 15; k++) begin
      r = int'($urandom_range(2, 0));
      xact(1'b1, r == 0, r != 0, 4'($urandom), $urandom, $urandom, 1'b0, "rnd_b");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
